// File: rtl/fetch_unit.sv
// Single-outstanding instruction fetch front end: REQ -> WAIT -> HOLD handshake
// between instruction memory and decode, with branch redirect and response discard.
module fetch_unit #(
  parameter logic [63:0] RESET_PC = 64'h0
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [63:0] imem_addr,
  input  logic        imem_rsp_valid,
  input  logic [31:0] imem_rsp_data,
  output logic        inst_valid,
  input  logic        inst_ready,
  output logic [31:0] inst,
  output logic [63:0] inst_pc,
  output logic [6:0]  opcode,
  output logic [2:0]  funct3,
  output logic [6:0]  funct7,
  input  logic        branch_taken,
  input  logic [63:0] branch_target,
  output logic [31:0] fetch_count
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2,
    HOLD = 2'd3
  } state_t;

  localparam logic [31:0] NOP        = 32'h0000_0013;
  localparam logic [63:0] RESET_PC_A = {RESET_PC[63:2], 2'b00};

  state_t      state;
  logic [63:0] pc;
  logic        discard;
  logic [63:0] redirect_pc;
  logic        unused_tgt_bits;

  assign redirect_pc     = {branch_target[63:2], 2'b00};
  assign unused_tgt_bits = ^branch_target[1:0];

  assign imem_addr = pc;
  assign opcode    = inst[6:0];
  assign funct3    = inst[14:12];
  assign funct7    = inst[31:25];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state          <= IDLE;
      pc             <= RESET_PC_A;
      discard        <= 1'b0;
      inst           <= NOP;
      inst_pc        <= 64'h0;
      fetch_count    <= 32'h0;
      imem_req_valid <= 1'b0;
      inst_valid     <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          state          <= REQ;
          imem_req_valid <= 1'b1;
        end

        REQ: begin
          // A request accepted in the same cycle as a redirect still occupies
          // memory, so its response must be waited for and then dropped.
          if (branch_taken) begin
            pc <= redirect_pc;
            if (imem_req_ready) begin
              state          <= WAIT;
              discard        <= 1'b1;
              imem_req_valid <= 1'b0;
            end
          end else if (imem_req_ready) begin
            state          <= WAIT;
            imem_req_valid <= 1'b0;
          end
        end

        WAIT: begin
          if (branch_taken) pc <= redirect_pc;
          if (imem_rsp_valid) begin
            if (branch_taken || discard) begin
              state          <= REQ;
              discard        <= 1'b0;
              imem_req_valid <= 1'b1;
            end else begin
              inst       <= imem_rsp_data;
              inst_pc    <= pc;
              pc         <= pc + 64'd4;
              state      <= HOLD;
              inst_valid <= 1'b1;
            end
          end else if (branch_taken) begin
            discard <= 1'b1;
          end
        end

        HOLD: begin
          // Redirect wins over a same-cycle consume: the held word is flushed.
          if (branch_taken) begin
            pc             <= redirect_pc;
            inst           <= NOP;
            inst_pc        <= 64'h0;
            state          <= REQ;
            inst_valid     <= 1'b0;
            imem_req_valid <= 1'b1;
          end else if (inst_ready) begin
            fetch_count    <= fetch_count + 32'd1;
            inst           <= NOP;
            inst_pc        <= 64'h0;
            state          <= REQ;
            inst_valid     <= 1'b0;
            imem_req_valid <= 1'b1;
          end
        end

        default: begin
          state          <= IDLE;
          imem_req_valid <= 1'b0;
          inst_valid     <= 1'b0;
        end
      endcase
    end
  end

endmodule
